bf_ctrl: RTL

- Sequencer and memory-port owner for the BF core.
- Accepts a length-prefixed program byte stream from a host and zero-clears the data RAM.
- Writes the program into program RAM, then releases the core and monitors it for completion or timeout.
- Owns the single data-RAM write port: it drives the port itself during clear and passes the core's cursor/out/we through during run.

---
 rtl/bf_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/bf_ctrl.sv
// bf_ctrl: BF core sequencer; loads program, clears data RAM, runs and monitors the core.
module bf_ctrl #(
  parameter int          CLEAR_WORDS    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] prg_addr,
  output logic [3:0]  prg_wdata,
  output logic        prg_we,
  input  logic [15:0] core_pc,
  input  logic [15:0] core_cursor,
  input  logic [7:0]  core_out,
  input  logic        core_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        core_reset,
  output logic        core_run,
  output logic [15:0] prog_len,
  output logic        busy,
  output logic        done,
  output logic        timeout
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, CLEAR, LOAD, RUN, DONE} state_t;
  localparam logic [15:0] K_LAST = 16'(CLEAR_WORDS - 1);
  localparam logic [31:0] T_LAST = 32'(TIMEOUT_CYCLES - 1);
  state_t state, next;
  logic [15:0] k, j;
  logic [31:0] rc;
  logic        pc_ge, xfer, tmo_hit;
  assign xfer    = in_valid & in_ready;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (rc == T_LAST);
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: if (start) next = LEN_LO;
      LEN_LO:     if (xfer) next = LEN_HI;
      LEN_HI:     if (xfer) next = CLEAR;
      CLEAR:      if (k == K_LAST) next = (prog_len != 16'd0) ? LOAD : RUN;
      LOAD:       if (j == prog_len) next = RUN;
      RUN:        if (pc_ge || tmo_hit) next = DONE;
      default:    next = IDLE;
    endcase
    if (abort) next = IDLE;
  end
  always_comb begin
    core_run   = state == RUN;
    core_reset = !core_run;
    in_ready   = state == LEN_LO || state == LEN_HI || (state == LOAD && j != prog_len);
    mem_addr   = state == CLEAR ? k : core_run ? core_cursor : 16'd0;
    mem_wdata  = core_run ? core_out : 8'd0;
    mem_we     = state == CLEAR || (core_run && core_we);
    busy       = state != IDLE && state != DONE;
    done       = state == DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      prog_len  <= '0;
      k         <= '0;
      j         <= '0;
      rc        <= '0;
      pc_ge     <= 1'b0;
      timeout   <= 1'b0;
      prg_we    <= 1'b0;
      prg_addr  <= '0;
      prg_wdata <= '0;
    end else begin
      k      <= state == CLEAR ? k + 16'd1 : 16'd0;
      j      <= state == LOAD ? j + {15'd0, xfer} : 16'd0;
      rc     <= state == RUN ? rc + 32'd1 : 32'd0;
      pc_ge  <= state == RUN && core_pc >= prog_len;
      prg_we <= state == LOAD && xfer && !abort;
      if (state == LOAD && xfer) begin
        prg_addr  <= j;
        prg_wdata <= in_data[3:0];
      end
      if (state == LEN_LO && xfer) prog_len[7:0] <= in_data;
      if (state == LEN_HI && xfer) prog_len[15:8] <= in_data;
      if ((state == IDLE || state == DONE) && start && !abort) timeout <= 1'b0;
      else if (state == RUN && !abort && !pc_ge && tmo_hit) timeout <= 1'b1;
    end
  end
endmodule
